// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: product = quotient * divisor + remainder.
// One multiplier bit is retired per RUN cycle, so a result takes divisorBITS+2 clocks.
module shift_add_multiplier #(
    parameter int divisorBITS  = 8,
    parameter int dividendBITS = 16,
    parameter int prodBITS     = divisorBITS + dividendBITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [dividendBITS-1:0] mul_quotient_in,
    input  logic [divisorBITS-1:0]  mul_divisor_in,
    input  logic [divisorBITS-1:0]  mul_remainder_in,
    output logic [prodBITS-1:0]     mul_product_out,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = (divisorBITS > 1) ? $clog2(divisorBITS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(divisorBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [prodBITS-1:0]    mcand;
    logic [divisorBITS-1:0] mplier;
    logic [prodBITS-1:0]    acc;
    logic [prodBITS-1:0]    acc_next;
    logic [CNT_W-1:0]       count;
    logic                   last_iter;

    // Shifted multiplicand contributes only when the current multiplier bit is set.
    function automatic logic [prodBITS-1:0] partial_term(
        input logic [prodBITS-1:0] m,
        input logic                bit_set
    );
        return bit_set ? m : '0;
    endfunction

    assign last_iter = (count == LAST_ITER);
    assign acc_next  = acc + partial_term(mcand, mplier[0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Product register is written only on the RUN->DONE step, so it stays put between results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand           <= '0;
            mplier          <= '0;
            acc             <= '0;
            count           <= '0;
            mul_product_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= prodBITS'(mul_quotient_in);
                        mplier <= mul_divisor_in;
                        acc    <= prodBITS'(mul_remainder_in);
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        mul_product_out <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: vector table plus hand-written
// sequences for reset, ignored restarts and back-to-back operation.
module tb_shift_add_multiplier;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] q     = '0;
    logic [7:0]  d     = '0;
    logic [7:0]  r     = '0;
    logic [23:0] prod;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  d;
        logic [7:0]  r;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[9];

    shift_add_multiplier #(
        .divisorBITS (8),
        .dividendBITS(16),
        .prodBITS    (24)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .mul_quotient_in (q),
        .mul_divisor_in  (d),
        .mul_remainder_in(r),
        .mul_product_out (prod),
        .busy            (busy),
        .done            (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Presents one start pulse, then scrambles operands and observes 12 cycles.
    // Latency counts the start cycle through the done cycle inclusive.
    task automatic run_op(input logic wait_edge, input logic [15:0] vq, input logic [7:0] vd,
                          input logic [7:0] vr, output int lat, output int busy_cnt,
                          output int done_cnt, output logic [23:0] p_done);
        if (wait_edge) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
        start = 1'b1;
        q = vq; d = vd; r = vr;
        @(posedge clock); #1;
        start = 1'b0;
        q = 16'($urandom); d = 8'($urandom); r = 8'($urandom);
        lat = -1; busy_cnt = 0; done_cnt = 0; p_done = 'x;
        for (int c = 1; c <= 12; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = c + 1;
                    p_done = prod;
                end
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        int          lat, bc, dc, k, last_c, n_done;
        int          cyc_done[3];
        logic [23:0] p;
        logic [15:0] cq[3];
        logic [7:0]  cd[3];
        logic [7:0]  cr[3];
        logic [23:0] cexp[3];

        vecs[0] = '{16'd1000,  8'd7,   8'd3,   24'd7003};
        vecs[1] = '{16'd65535, 8'd255, 8'd255, 24'd16711680};
        vecs[2] = '{16'd1234,  8'd0,   8'd17,  24'd17};
        vecs[3] = '{16'd0,     8'd255, 8'd0,   24'd0};
        vecs[4] = '{16'd1,     8'd1,   8'd0,   24'd1};
        vecs[5] = '{16'd12345, 8'd128, 8'd5,   24'd1580165};
        vecs[6] = '{16'd300,   8'd200, 8'd100, 24'd60100};
        vecs[7] = '{16'd65535, 8'd1,   8'd0,   24'd65535};
        vecs[8] = '{16'd0,     8'd0,   8'd255, 24'd255};

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_prod", 64'(prod), 64'd0);

        // Start presented together with reset release: sampled on the first edge.
        @(posedge clock); #1;
        run_op(1'b0, 16'd1000, 8'd7, 8'd3, lat, bc, dc, p);
        check("first_edge_prod", 64'(p), 64'd7003);
        check("first_edge_lat", 64'(lat), 64'd10);

        for (int i = 0; i < 9; i++) begin
            run_op(1'b1, vecs[i].q, vecs[i].d, vecs[i].r, lat, bc, dc, p);
            check($sformatf("vec%0d_prod", i), 64'(p), 64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd10);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd9);
            check($sformatf("vec%0d_done_pulses", i), 64'(dc), 64'd1);
            check($sformatf("vec%0d_prod_hold", i), 64'(prod), 64'(vecs[i].exp));
        end

        // Second start with different operands while busy must be ignored.
        @(posedge clock); #1;
        start = 1'b1; q = 16'd1000; d = 8'd7; r = 8'd3;
        @(posedge clock); #1;
        start = 1'b0;
        dc = 0; bc = 0; p = 'x;
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) begin
                start = 1'b1; q = 16'd5; d = 8'd5; r = 8'd5;
            end
            if (c == 6) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                dc++;
                p = prod;
            end
            @(posedge clock); #1;
        end
        check("ignore_prod", 64'(p), 64'd7003);
        check("ignore_done_pulses", 64'(dc), 64'd1);
        check("ignore_busy_cycles", 64'(bc), 64'd9);

        // Reset in RUN cycle 4 abandons the operation at once.
        @(posedge clock); #1;
        start = 1'b1; q = 16'd50000; d = 8'd200; r = 8'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_prod", 64'(prod), 64'd0);
        dc = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) dc++;
            @(posedge clock); #1;
        end
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) dc++;
            @(posedge clock); #1;
        end
        check("midrun_reset_no_done", 64'(dc), 64'd0);
        check("midrun_reset_prod_after", 64'(prod), 64'd0);
        run_op(1'b1, 16'd50000, 8'd200, 8'd9, lat, bc, dc, p);
        check("after_reset_prod", 64'(p), 64'd10000009);
        check("after_reset_latency", 64'(lat), 64'd10);

        // Start held high: new operands are loaded right after each done.
        cq[0] = 16'd1000;  cd[0] = 8'd7;   cr[0] = 8'd3;   cexp[0] = 24'd7003;
        cq[1] = 16'd2;     cd[1] = 8'd3;   cr[1] = 8'd4;   cexp[1] = 24'd10;
        cq[2] = 16'd40000; cd[2] = 8'd250; cr[2] = 8'd200; cexp[2] = 24'd10000200;
        @(posedge clock); #1;
        start = 1'b1; q = cq[0]; d = cd[0]; r = cr[0];
        k = 0; n_done = 0; last_c = 0;
        for (int c = 1; c <= 35; c++) begin
            @(posedge clock); #1;
            if (done) begin
                n_done++;
                if (k < 3) begin
                    cyc_done[k] = c;
                    check($sformatf("b2b%0d_prod", k), 64'(prod), 64'(cexp[k]));
                    k++;
                    if (k < 3) begin
                        q = cq[k]; d = cd[k]; r = cr[k];
                    end else begin
                        start = 1'b0;
                    end
                end
            end
            last_c = c;
        end
        start = 1'b0;
        check("b2b_done_count", 64'(n_done), 64'd3);
        if (k == 3) begin
            check("b2b_first_latency", 64'(cyc_done[0] + 1), 64'd10);
            check("b2b_gap1", 64'(cyc_done[1] - cyc_done[0]), 64'd10);
            check("b2b_gap2", 64'(cyc_done[2] - cyc_done[1]), 64'd10);
        end else begin
            check("b2b_results_seen", 64'(k), 64'd3);
        end
        check("b2b_window", 64'(last_c), 64'd35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
